// File: rtl/usb_tx_sched_pkg.sv
// Shared widths and scheduler state codes for the USB TX scheduler.
// Latency: n/a (types only); backpressure: n/a.
package usb_tx_sched_pkg;

  localparam int USB_ADDR_NBIT = 9;
  localparam int USB_DATA_NBIT = 16;

  localparam logic [USB_ADDR_NBIT-1:0] USB_ADDR_LAST = '1;

  typedef enum logic [2:0] {
    ST_SYNC = 3'd0,
    ST_ARB  = 3'd1,
    ST_SOP  = 3'd2,
    ST_XFER = 3'd3,
    ST_DONE = 3'd4,
    ST_GAP  = 3'd5
  } txs_state_t;

endpackage

// File: rtl/usb_tx_sched_rr_arb.sv
// Round-robin picker: first set request after the pointer, wrapping at NREQ-1.
// Latency: combinational; backpressure: none, caller decides when to accept the winner.
module usb_tx_sched_rr_arb #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_win,
  output logic [PTR_W-1:0] o_win_idx,
  output logic             o_any
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_win     = '0;
    o_win_idx = i_ptr;
    o_any     = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    // Scan ptr+1 .. ptr+NREQ so the previous winner is considered last.
    for (int k = 1; k <= NREQ; k++) begin
      w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NREQ)) w_sum = w_sum - (PTR_W+1)'(NREQ);
      w_idx = w_sum[PTR_W-1:0];
      if (!o_any && i_req[w_idx]) begin
        o_any        = 1'b1;
        o_win[w_idx] = 1'b1;
        o_win_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/usb_tx_sched.sv
// Round-robin owner of the slavefifo TX path; req->gnt 1 cycle, req->tx_cache_sop 2 cycles.
// Grant waits while RX is active; watchdog abort only with USB_TX_SCHED_WDOG_EN defined.
module usb_tx_sched
  import usb_tx_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int SYNC_CYC = 4
`ifdef USB_TX_SCHED_WDOG_EN
  ,
  parameter int WDOG_CYC = 65535
`endif
) (
  input  logic                            ifclk,
  input  logic                            rst_n,
  input  logic [NREQ-1:0]                 req,
  input  logic [NREQ*USB_DATA_NBIT-1:0]   src_data,
  output logic [NREQ-1:0]                 gnt,
  output logic [NREQ-1:0]                 done,
  output logic [USB_ADDR_NBIT-1:0]        src_addr,
  output logic                            tx_cache_sop,
  input  logic [USB_ADDR_NBIT-1:0]        tx_cache_addr,
  output logic [USB_DATA_NBIT-1:0]        tx_cache_data,
  input  logic                            rx_cache_sop,
  input  logic                            rx_cache_eop,
  output logic                            busy,
  output logic                            timeout
);

  localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SCNT_W = $clog2(SYNC_CYC + 1);

  txs_state_t        r_state, w_state_nxt;
  logic [NREQ-1:0]   r_gnt, w_gnt_nxt, w_win;
  logic [PTR_W-1:0]  r_ptr, w_ptr_nxt, w_win_idx;
  logic [SCNT_W-1:0] r_scnt, w_scnt_nxt;
  logic              r_rx_busy, w_rx_busy_nxt, r_sop;
  logic              w_any, w_wdog_hit, w_timeout;

  // Arbitration looks at the next rx_busy value so an RX start blocks a grant that same cycle.
  assign w_rx_busy_nxt = rx_cache_sop | (r_rx_busy & ~rx_cache_eop);

  usb_tx_sched_rr_arb #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
    .i_req     (req),
    .i_ptr     (r_ptr),
    .o_win     (w_win),
    .o_win_idx (w_win_idx),
    .o_any     (w_any)
  );

`ifdef USB_TX_SCHED_WDOG_EN
  logic [15:0] r_wdog;

  always_ff @(posedge ifclk or negedge rst_n) begin
    if (!rst_n)                 r_wdog <= '0;
    else if (r_state != ST_XFER) r_wdog <= '0;
    else                        r_wdog <= r_wdog + 16'd1;
  end

  assign w_wdog_hit = (r_state == ST_XFER) && (r_wdog == 16'(WDOG_CYC - 1));
`else
  assign w_wdog_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_scnt_nxt  = r_scnt;
    w_timeout   = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (tx_cache_addr != '0) begin
          w_scnt_nxt = '0;
        end else if (r_scnt == SCNT_W'(SYNC_CYC - 1)) begin
          w_scnt_nxt  = '0;
          w_state_nxt = ST_ARB;
        end else begin
          w_scnt_nxt = r_scnt + SCNT_W'(1);
        end
      end
      ST_ARB: begin
        if (w_any && !w_rx_busy_nxt) begin
          w_gnt_nxt   = w_win;
          w_ptr_nxt   = w_win_idx;
          w_state_nxt = ST_SOP;
        end
      end
      ST_SOP:  w_state_nxt = ST_XFER;
      ST_XFER: begin
        if (tx_cache_addr == USB_ADDR_LAST) begin
          w_state_nxt = ST_DONE;
        end else if (w_wdog_hit) begin
          w_timeout   = 1'b1;
          w_gnt_nxt   = '0;
          w_state_nxt = ST_SYNC;
        end
      end
      ST_DONE: begin
        w_gnt_nxt   = '0;
        w_state_nxt = ST_GAP;
      end
      ST_GAP:  w_state_nxt = ST_ARB;
      default: w_state_nxt = ST_SYNC;
    endcase
  end

  always_ff @(posedge ifclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_SYNC;
      r_gnt     <= '0;
      r_ptr     <= PTR_W'(NREQ - 1);
      r_scnt    <= '0;
      r_rx_busy <= 1'b0;
      r_sop     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_scnt    <= w_scnt_nxt;
      r_rx_busy <= w_rx_busy_nxt;
      r_sop     <= (r_state == ST_SOP);
    end
  end

  always_comb begin
    tx_cache_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gnt[i]) tx_cache_data = tx_cache_data | src_data[i*USB_DATA_NBIT +: USB_DATA_NBIT];
    end
  end

  assign gnt          = r_gnt;
  assign done         = (r_state == ST_DONE) ? r_gnt : '0;
  assign src_addr     = tx_cache_addr;
  assign tx_cache_sop = r_sop;
  assign busy         = (r_state != ST_ARB);
  assign timeout      = w_timeout;

endmodule
